// File: rtl/serial_complement.sv
// Bit-serial one's/two's complementer: consumes an operand LSB first and
// streams the complemented bits out one cycle later, assembling the full word.
module serial_complement #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic             in_valid,
   input  logic             in_data,
   output logic             busy,
   output logic             out_valid,
   output logic             out_data,
   output logic [WIDTH-1:0] word_out,
   output logic             done,
   output logic             ovf,
   output logic             zero
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_COPY = 2'd1,
      ST_INV  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_r;
   state_t           state_nxt_s;
   logic             mode_r;
   logic             mode_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [WIDTH-1:0] shift_r;
   logic [WIDTH-1:0] shift_nxt_s;
   logic             zero_trk_r;
   logic             zero_trk_nxt_s;
   logic             res_bit_s;

   logic             busy_r;
   logic             out_valid_r;
   logic             out_valid_nxt_s;
   logic             out_data_r;
   logic             out_data_nxt_s;
   logic [WIDTH-1:0] word_out_r;
   logic [WIDTH-1:0] word_nxt_s;
   logic             done_r;
   logic             done_nxt_s;
   logic             ovf_r;
   logic             ovf_nxt_s;
   logic             zero_r;
   logic             zero_nxt_s;

   // Next-state and next-output logic for the complement FSM and datapath.
   always_comb begin
      state_nxt_s     = state_r;
      mode_nxt_s      = mode_r;
      cnt_nxt_s       = cnt_r;
      shift_nxt_s     = shift_r;
      zero_trk_nxt_s  = zero_trk_r;
      res_bit_s       = 1'b0;
      out_valid_nxt_s = 1'b0;
      out_data_nxt_s  = 1'b0;
      word_nxt_s      = word_out_r;
      done_nxt_s      = 1'b0;
      ovf_nxt_s       = 1'b0;
      zero_nxt_s      = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (start) begin
               mode_nxt_s     = mode;
               cnt_nxt_s      = {CNT_W{1'b0}};
               shift_nxt_s    = {WIDTH{1'b0}};
               zero_trk_nxt_s = 1'b1;
               state_nxt_s    = mode ? ST_COPY : ST_INV;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_COPY, ST_INV: begin
            if (in_valid) begin
               res_bit_s       = (state_r == ST_COPY) ? in_data : ~in_data;
               out_valid_nxt_s = 1'b1;
               out_data_nxt_s  = res_bit_s;
               zero_trk_nxt_s  = zero_trk_r & ~in_data;
               // Loop-based write keeps the index width independent of CNT_W.
               for (int i = 0; i < WIDTH; i++) begin
                  if (cnt_r == CNT_W'(i)) begin
                     shift_nxt_s[i] = res_bit_s;
                  end else begin
                     shift_nxt_s[i] = shift_r[i];
                  end
               end
               if (cnt_r == LAST_IDX) begin
                  // Overflow: the only 1 sits in the MSB, so two's complement maps it onto itself.
                  state_nxt_s = ST_IDLE;
                  done_nxt_s  = 1'b1;
                  word_nxt_s  = shift_nxt_s;
                  zero_nxt_s  = zero_trk_r & ~in_data;
                  ovf_nxt_s   = mode_r & zero_trk_r & in_data;
               end else begin
                  cnt_nxt_s = cnt_r + CNT_ONE;
                  if ((state_r == ST_COPY) && in_data) begin
                     state_nxt_s = ST_INV;
                  end else begin
                     state_nxt_s = state_r;
                  end
               end
            end else begin
               state_nxt_s = state_r;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Datapath and registered output stage.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mode_r      <= 1'b0;
         cnt_r       <= {CNT_W{1'b0}};
         shift_r     <= {WIDTH{1'b0}};
         zero_trk_r  <= 1'b0;
         busy_r      <= 1'b0;
         out_valid_r <= 1'b0;
         out_data_r  <= 1'b0;
         word_out_r  <= {WIDTH{1'b0}};
         done_r      <= 1'b0;
         ovf_r       <= 1'b0;
         zero_r      <= 1'b0;
      end else begin
         mode_r      <= mode_nxt_s;
         cnt_r       <= cnt_nxt_s;
         shift_r     <= shift_nxt_s;
         zero_trk_r  <= zero_trk_nxt_s;
         busy_r      <= (state_nxt_s != ST_IDLE);
         out_valid_r <= out_valid_nxt_s;
         out_data_r  <= out_data_nxt_s;
         word_out_r  <= word_nxt_s;
         done_r      <= done_nxt_s;
         ovf_r       <= ovf_nxt_s;
         zero_r      <= zero_nxt_s;
      end
   end

   assign busy      = busy_r;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign word_out  = word_out_r;
   assign done      = done_r;
   assign ovf       = ovf_r;
   assign zero      = zero_r;

endmodule

// File: tb/tb_serial_complement.sv
// Self-checking bench for serial_complement: directed words, randomized words
// with stalls, ignored start/in_valid, and mid-word reset.
module tb_serial_complement;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic         mode;
   logic         in_valid;
   logic         in_data;
   logic         busy;
   logic         out_valid;
   logic         out_data;
   logic [W-1:0] word_out;
   logic         done;
   logic         ovf;
   logic         zero;

   int           n_cmp;
   int           n_mis;
   logic [W-1:0] exp_word;

   serial_complement #(.WIDTH(W), .CNT_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .busy      (busy),
      .out_valid (out_valid),
      .out_data  (out_data),
      .word_out  (word_out),
      .done      (done),
      .ovf       (ovf),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Arithmetic reference: one's = bitwise NOT, two's = negation modulo 2**W.
   function automatic logic [W-1:0] ref_result(input logic [W-1:0] op, input logic md);
      logic [W-1:0] r;
      if (md) r = W'(0) - op;
      else    r = ~op;
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag, input logic exp_busy);
      check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
      check({tag, "_ov"},   32'(out_valid), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_zero"}, 32'(zero), 32'd0);
      check({tag, "_ovf"},  32'(ovf), 32'd0);
      check({tag, "_word"}, 32'(word_out), 32'(exp_word));
   endtask

   // Streams one operand; gap_at inserts gap_len stalls before that bit index.
   task automatic run_word(input logic [W-1:0] op, input logic md, input bit rand_gaps,
                           input int gap_at, input int gap_len);
      logic [W-1:0] res;
      logic         exp_zero;
      logic         exp_ovf;
      res      = ref_result(op, md);
      exp_zero = (op == W'(0));
      exp_ovf  = md && (op == (W'(1) << (W - 1)));
      start    = 1'b1;
      mode     = md;
      in_valid = 1'b0;
      in_data  = 1'($urandom);
      tick();
      check("start", 32'(busy), 32'd1);
      check("start_ov", 32'(out_valid), 32'd0);
      start = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (i == gap_at) begin
            for (int g = 0; g < gap_len; g++) begin
               in_valid = 1'b0;
               in_data  = 1'($urandom);
               tick();
               check_quiet("gap", 1'b1);
            end
         end
         while (rand_gaps && ($urandom_range(0, 3) == 0)) begin
            in_valid = 1'b0;
            in_data  = 1'($urandom);
            start    = 1'($urandom);
            mode     = 1'($urandom);
            tick();
            check_quiet("stall", 1'b1);
         end
         in_valid = 1'b1;
         in_data  = op[i];
         start    = rand_gaps ? 1'($urandom) : 1'b0;
         mode     = rand_gaps ? 1'($urandom) : md;
         tick();
         check("bit_ov", 32'(out_valid), 32'd1);
         check("bit_data", 32'(out_data), 32'(res[i]));
         if (i == W - 1) begin
            exp_word = res;
            check("last_done", 32'(done), 32'd1);
            check("last_busy", 32'(busy), 32'd0);
            check("last_word", 32'(word_out), 32'(exp_word));
            check("last_zero", 32'(zero), 32'(exp_zero));
            check("last_ovf", 32'(ovf), 32'(exp_ovf));
         end else begin
            check("mid_done", 32'(done), 32'd0);
            check("mid_busy", 32'(busy), 32'd1);
            check("mid_word", 32'(word_out), 32'(exp_word));
            check("mid_flags", 32'({zero, ovf}), 32'd0);
         end
      end
      start    = 1'b0;
      in_valid = 1'b0;
      tick();
      check_quiet("post", 1'b0);
   endtask

   initial begin
      n_cmp    = 0;
      n_mis    = 0;
      exp_word = '0;
      rst      = 1'b0;
      start    = 1'b0;
      mode     = 1'b0;
      in_valid = 1'b0;
      in_data  = 1'b0;
      tick();
      tick();
      check_quiet("reset", 1'b0);
      check("reset_data", 32'(out_data), 32'd0);
      rst = 1'b1;
      tick();

      run_word(8'h5A, 1'b0, 1'b0, -1, 0);
      run_word(8'h0C, 1'b1, 1'b0, -1, 0);
      run_word(8'h80, 1'b1, 1'b0, -1, 0);
      run_word(8'h00, 1'b1, 1'b0, -1, 0);
      run_word(8'h36, 1'b1, 1'b0, 4, 3);
      run_word(8'h00, 1'b0, 1'b0, -1, 0);
      run_word(8'h80, 1'b0, 1'b0, -1, 0);

      // Mid-word reset aborts with no done and clears word_out.
      start = 1'b1;
      mode  = 1'b0;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 1'($urandom);
         tick();
      end
      in_valid = 1'b0;
      rst      = 1'b0;
      tick();
      exp_word = '0;
      check_quiet("abort", 1'b0);
      check("abort_data", 32'(out_data), 32'd0);
      rst = 1'b1;
      tick();
      check_quiet("abort_rel", 1'b0);
      run_word(8'hFF, 1'b0, 1'b0, -1, 0);

      // in_valid while idle must not start or disturb anything.
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 1'($urandom);
         tick();
         check_quiet("idle_iv", 1'b0);
      end
      in_valid = 1'b0;

      for (int k = 0; k < 40; k++) begin
         logic [W-1:0] op;
         case ($urandom_range(0, 5))
            0:       op = 8'h80;
            1:       op = 8'h00;
            default: op = W'($urandom);
         endcase
         run_word(op, 1'($urandom), 1'b1, -1, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
